e_mdu: RTL

Multiply/divide unit of the execute stage. Takes the same forwarded operands as the E-stage ALU, runs MULT/MULTU/DIV/DIVU as a fixed-latency multi-cycle operation, and owns the architectural HI/LO registers. HI and LO feed the E-stage result mux alongside ALUOut for MFHI/MFLO. Busy drives the hazard unit's stall of D/E.

---
 rtl/e_mdu_pkg.sv | 22 ++
 rtl/e_mdu_div.sv | 38 +++
 rtl/e_mdu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared encodings and defaults for the E-stage multiply/divide unit
package e_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'b000,
        MDU_MULT  = 3'b001,
        MDU_MULTU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110
    } mdu_op_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/e_mdu_div.sv
// rtl/e_mdu_div.sv - combinational 32-bit signed/unsigned divider with zero and INT_MIN/-1 handling
module e_mdu_div (
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;

    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend
    always_comb begin
        div_zero = (divisor == 32'd0);
        neg_a    = is_signed & dividend[31];
        neg_b    = is_signed & divisor[31];
        mag_a    = neg_a ? (32'd0 - dividend) : dividend;
        mag_b    = neg_b ? (32'd0 - divisor) : divisor;
        // keep the divide operator away from a zero divisor; the result is discarded anyway
        safe_b   = div_zero ? 32'd1 : mag_b;
        mag_q    = mag_a / safe_b;
        mag_r    = mag_a % safe_b;
        quo      = (neg_a ^ neg_b) ? (32'd0 - mag_q) : mag_q;
        rem      = neg_a ? (32'd0 - mag_r) : mag_r;
        if (is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end
    end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit owning HI/LO; divider built only with MDU_DIV_EN
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  MDUOp,
    input  logic        Start,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;

    logic             is_mul;
    logic             is_div;
    logic             load_mul;
    logic             load_div;
    logic             done;
    logic             wr_hi;
    logic             wr_lo;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [63:0]      div_res;

    assign is_mul = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);

    // Sign-extend to 64 bits so a plain 64-bit multiply yields the signed product
    assign prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
    assign prod_u = {32'd0, SrcA} * {32'd0, SrcB};

`ifdef MDU_DIV_EN
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_zero;

    assign is_div = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);

    e_mdu_div u_div (
        .is_signed (MDUOp == MDU_DIV),
        .dividend  (SrcA),
        .divisor   (SrcB),
        .quo       (div_quo),
        .rem       (div_rem),
        .div_zero  (div_zero)
    );

    // A zero divisor re-commits the current HI/LO, which cannot change while busy
    assign div_res = div_zero ? {HI, LO} : {div_rem, div_quo};
`else
    assign is_div  = 1'b0;
    assign div_res = 64'd0;
`endif

    assign Busy  = (state_q == ST_BUSY);
    assign Stall = Busy | (Start & (is_mul | is_div));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-edge actions; requests arriving while busy are dropped
    always_comb begin
        state_d  = state_q;
        load_mul = 1'b0;
        load_div = 1'b0;
        done     = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (is_mul) begin
                        load_mul = 1'b1;
                        state_d  = ST_BUSY;
                    end else if (is_div) begin
                        load_div = 1'b1;
                        state_d  = ST_BUSY;
                    end else if (MDUOp == MDU_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (MDUOp == MDU_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latency counter, pending result capture and architectural HI/LO update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            if (load_mul) begin
                {pend_hi, pend_lo} <= (MDUOp == MDU_MULT) ? prod_s : prod_u;
                cnt_q              <= CNT_W'(MUL_LAT - 1);
            end else if (load_div) begin
                {pend_hi, pend_lo} <= div_res;
                cnt_q              <= CNT_W'(DIV_LAT - 1);
            end else if (Busy && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (wr_hi) begin
                HI <= SrcA;
            end
            if (wr_lo) begin
                LO <= SrcA;
            end
        end
    end

endmodule
